max_track_scan_ctrl: RTL
========================

// Module: max_track_scan_ctrl
// PURPOSE
// - Sequences a full sweep of the tracker actuator to find the position of maximum panel voltage.
// - At each position: waits for mechanical settle, triggers one ADC conversion, compares the sample
//   against the stored maximum LV, and pulses GT so the max register captures the new sample.
// - At end of sweep: parks the actuator on the best position and pulses DONE.
// - Sits between the ADC interface, the max-voltage register (GT/PV/LV) and the servo position driver.
// PARAMETERS
// DATA_W      12      ADC sample / LV width
// POS_W       8       actuator position width
// POS_MIN     0       first sweep position
// POS_MAX     180     last allowed sweep position (inclusive)
// POS_STEP    4       position increment per step, >=1
// SETTLE_CYC  50000   CLK cycles to wait after each POS change, >=1
// ADC_TO      1024    CLK cycles to wait for ADC_VALID before timeout
// THRESH      4       hysteresis: new max only if ADC_DATA > LV + THRESH
// PORTS
// CLK        in   1       system clock, rising edge
// RST_N      in   1       asynchronous active-low reset
// START      in   1       1-cycle pulse: begin a sweep (ignored while BUSY)
// ABORT      in   1       level: terminate sweep, park
// ADC_DATA   in   DATA_W  conversion result, valid when ADC_VALID=1
// ADC_VALID  in   1       1-cycle result strobe
// LV         in   DATA_W  current stored maximum from max register
// ADC_START  out  1       1-cycle conversion request
// GT         out  1       1-cycle load enable to max register
// PV         out  DATA_W  value presented to max register (registered ADC_DATA)
// POS        out  POS_W   actuator position command
// BEST_POS   out  POS_W   position of current maximum
// BUSY       out  1       high from START acceptance until DONE/abort
// DONE       out  1       1-cycle pulse at sweep completion or abort
// ERR        out  1       sticky: any ADC timeout this sweep; cleared on accepted START
// BEHAVIOUR
// - Reset: state IDLE; POS=BEST_POS=POS_MIN; PV=0; ADC_START=GT=BUSY=DONE=ERR=0; first-flag set.
// - States: IDLE -> SETTLE -> CONV -> WAIT -> CMP -> (STEP -> SETTLE | PARK) ; PARK -> SETTLE_P -> IDLE.
// - IDLE: START=1 -> POS<=POS_MIN, BUSY<=1, ERR<=0, first<=1, go SETTLE.
// - SETTLE: count SETTLE_CYC cycles, then CONV. CONV: ADC_START=1 one cycle, go WAIT.
// - WAIT: ADC_VALID sampled from cycle after ADC_START; on valid PV<=ADC_DATA, go CMP.
//   ADC_TO cycles without valid -> ERR<=1, sample skipped, go STEP-decision.
// - CMP (1 cycle): new = first | (ADC_DATA_reg > LV + THRESH), sum computed DATA_W+1 bits (no wrap).
//   new -> GT=1 this cycle with PV stable, BEST_POS<=POS, first<=0. LV expected updated next cycle.
// - STEP-decision: POS+POS_STEP computed POS_W+1 bits; if <= POS_MAX -> POS<=that, SETTLE; else PARK.
//   Last sample is the largest POS_MIN+k*POS_STEP <= POS_MAX; POS_MIN>POS_MAX: single sample at POS_MIN.
// - PARK: POS<=BEST_POS (unchanged if no valid sample), wait SETTLE_CYC, DONE=1 one cycle, BUSY<=0, IDLE.
// - ABORT=1 in any non-IDLE, non-PARK state: drop pending conversion (late ADC_VALID ignored), go PARK.
// - START while BUSY ignored; START and ABORT same cycle in IDLE: ABORT wins, nothing starts.
// - Reset mid-sweep: immediate return to reset values; external LV not cleared, so first-flag forces
//   first sample of next sweep to load regardless of stale LV.
// STRUCTURE
// - Package max_track_pkg: state enum, DATA_W/POS_W defaults, shared with ADC and comparator blocks.
// - One sub-module: settle_timer (loadable down counter, terminal-count flag), reused for SETTLE,
//   PARK settle and ADC timeout (reload ADC_TO in WAIT).
// TESTING
// - POS_MIN=0,POS_MAX=12,STEP=4, ADC returns 100,300,200,50 -> GT at pos 0,4; BEST_POS=4; POS parks 4; DONE once.
// - THRESH=4, LV=300, sample 304 -> no GT; sample 305 -> GT, PV=305.
// - POS_MAX=10,STEP=4 -> samples at 0,4,8 only; no POS value >10 ever driven.
// - ADC never responds at pos 4 -> ERR=1 after ADC_TO cycles, sweep continues, DONE pulses, ERR held to next START.
// - ABORT during WAIT at pos 8 (best=4) -> late ADC_VALID ignored, POS=4, DONE pulse, BUSY=0.
// - RST_N low mid-SETTLE -> all outputs to reset values asynchronously; next sweep first sample GT=1 with stale LV=4095.

Source files
------------

// File: rtl/max_track_scan_ctrl_pkg.sv
// Shared types and defaults for the max-power-point scan controller,
// its ADC front end and the max-voltage comparator.
package max_track_pkg;

  localparam int DATA_W_D = 12;
  localparam int POS_W_D  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CONV,
    S_WAIT,
    S_CMP,
    S_STEP,
    S_PARK,
    S_SETTLE_P
  } state_t;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/max_track_scan_ctrl_if.sv
// Bundle between the scan controller and the ADC, max register and
// servo driver; master is the surrounding system, slave the controller.
interface max_track_scan_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int POS_W  = 8
);

  logic              start;
  logic              abort;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic [DATA_W-1:0] lv;
  logic              adc_start;
  logic              gt;
  logic [DATA_W-1:0] pv;
  logic [POS_W-1:0]  pos;
  logic [POS_W-1:0]  best_pos;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, abort, adc_data, adc_valid, lv,
    output adc_start, gt, pv, pos, best_pos,
    output busy, done, err
  );

  modport master (
    output start, abort, adc_data, adc_valid, lv,
    input  adc_start, gt, pv, pos, best_pos,
    input  busy, done, err
  );

endinterface

// File: rtl/max_track_scan_ctrl_settle_timer.sv
// Loadable down counter; o_tc is high once the loaded
// number of cycles has elapsed and stays high until reloaded.
module settle_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val - 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/max_track_scan_ctrl.sv
// Sweeps the actuator, samples panel voltage at each step and
// parks on the position that produced the largest sample.
module max_track_scan_ctrl
  import max_track_pkg::*;
#(
  parameter int DATA_W     = DATA_W_D,
  parameter int POS_W      = POS_W_D,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 180,
  parameter int POS_STEP   = 4,
  parameter int SETTLE_CYC = 50000,
  parameter int ADC_TO     = 1024,
  parameter int THRESH     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  max_track_scan_ctrl_if.slave  io_bus
);

  localparam int TW = cnt_w(SETTLE_CYC, ADC_TO);

  localparam logic [TW-1:0]     L_SET = TW'(SETTLE_CYC);
  localparam logic [TW-1:0]     L_TO  = TW'(ADC_TO);
  localparam logic [POS_W-1:0]  L_MIN = POS_W'(POS_MIN);
  localparam logic [POS_W:0]    L_MAX = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]    L_STP = (POS_W+1)'(POS_STEP);
  localparam logic [DATA_W:0]   L_TH  = (DATA_W+1)'(THRESH);

  state_t            r_state;
  state_t            w_nxt;
  logic [POS_W-1:0]  r_pos;
  logic [POS_W-1:0]  r_best;
  logic [DATA_W-1:0] r_pv;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_first;

  logic              w_tc;
  logic              w_load;
  logic [TW-1:0]     w_lval;
  logic              w_adc_start;
  logic              w_gt;
  logic              w_accept;
  logic              w_sample;
  logic              w_timeout;
  logic              w_step;
  logic              w_finish;
  logic              w_new;
  logic [POS_W:0]    w_next_pos;

  settle_timer #(.W(TW)) u_tmr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_val   (w_lval),
    .o_tc    (w_tc)
  );

  // Widened by one bit so neither sum can wrap into a false pass
  assign w_next_pos = {1'b0, r_pos} + L_STP;
  assign w_new = r_first |
    ({1'b0, r_pv} > ({1'b0, io_bus.lv} + L_TH));

  always_comb begin
    w_nxt       = r_state;
    w_load      = 1'b0;
    w_lval      = L_SET;
    w_adc_start = 1'b0;
    w_gt        = 1'b0;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_timeout   = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io_bus.start && !io_bus.abort) begin
          w_accept = 1'b1;
          w_load   = 1'b1;
          w_nxt    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (io_bus.abort) w_nxt = S_PARK;
        else if (w_tc)    w_nxt = S_CONV;
      end
      S_CONV: begin
        if (io_bus.abort) begin
          w_nxt = S_PARK;
        end else begin
          w_adc_start = 1'b1;
          w_load      = 1'b1;
          w_lval      = L_TO;
          w_nxt       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (io_bus.abort) begin
          w_nxt = S_PARK;
        end else if (io_bus.adc_valid) begin
          w_sample = 1'b1;
          w_nxt    = S_CMP;
        end else if (w_tc) begin
          w_timeout = 1'b1;
          w_nxt     = S_STEP;
        end
      end
      S_CMP: begin
        if (io_bus.abort) begin
          w_nxt = S_PARK;
        end else begin
          w_gt  = w_new;
          w_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (io_bus.abort) begin
          w_nxt = S_PARK;
        end else if (w_next_pos <= L_MAX) begin
          w_step = 1'b1;
          w_load = 1'b1;
          w_nxt  = S_SETTLE;
        end else begin
          w_nxt = S_PARK;
        end
      end
      S_PARK: begin
        w_load = 1'b1;
        w_nxt  = S_SETTLE_P;
      end
      S_SETTLE_P: begin
        if (w_tc) begin
          w_finish = 1'b1;
          w_nxt    = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pos   <= L_MIN;
      r_best  <= L_MIN;
      r_pv    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_done  <= w_finish;
      if (w_accept) begin
        r_pos   <= L_MIN;
        r_busy  <= 1'b1;
        r_err   <= 1'b0;
        r_first <= 1'b1;
      end
      if (w_sample)  r_pv <= io_bus.adc_data;
      if (w_timeout) r_err <= 1'b1;
      if (w_gt) begin
        r_best  <= r_pos;
        r_first <= 1'b0;
      end
      if (w_step) r_pos <= w_next_pos[POS_W-1:0];
      // First still set means no sample landed; stay where we are
      if (r_state == S_PARK && !r_first) r_pos <= r_best;
      if (w_finish) r_busy <= 1'b0;
    end
  end

  assign io_bus.adc_start = w_adc_start;
  assign io_bus.gt        = w_gt;
  assign io_bus.pv        = r_pv;
  assign io_bus.pos       = r_pos;
  assign io_bus.best_pos  = r_best;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.err       = r_err;

endmodule
